// File: rtl/conv_encoder_pkg.sv
// Shared definitions for the K=7 convolutional encoder: 802.11 RATE field codes,
// generator taps, the code-rate enum and the RATE-code-to-code-rate mapping.
// RATE codes are the 4-bit SIGNAL RATE field with R1 in bit 0 (as in ieee80211_defs.v).
package conv_encoder_pkg;

   localparam logic [3:0] RATE_6M  = 4'b1011;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b1010;
   localparam logic [3:0] RATE_18M = 4'b1110;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1101;
   localparam logic [3:0] RATE_48M = 4'b1000;
   localparam logic [3:0] RATE_54M = 4'b1100;

   // Taps over the window {x, d1, d2, d3, d4, d5, d6}, x in bit 6.
   localparam logic [6:0] G0_TAPS = 7'o133;
   localparam logic [6:0] G1_TAPS = 7'o171;

   typedef enum logic [1:0] {
      RATE_1_2,
      RATE_2_3,
      RATE_3_4
   } rate_e;

   // Unknown codes fall back to the mother code so nothing is punctured away.
   function automatic rate_e rate_from_code(input logic [3:0] code);
      rate_e r;
      case (code)
         RATE_48M:                               r = RATE_2_3;
         RATE_9M, RATE_18M, RATE_36M, RATE_54M:  r = RATE_3_4;
         default:                                r = RATE_1_2;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/conv_puncture.sv
// Puncturer: packs mother-code bits A/B of one beat into the output word for the
// selected code rate; pattern restarts at bit 0 of every beat. Pure combinational.
// Ports: mother_a_i/mother_b_i (per input bit), rate_i -> packed_o (LSB first,
// unused upper bits zero), count_o (number of valid bits in packed_o).
module conv_puncture
   import conv_encoder_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0]   mother_a_i,
   input  logic [WIDTH-1:0]   mother_b_i,
   input  rate_e              rate_i,
   output logic [2*WIDTH-1:0] packed_o,
   output logic [7:0]         count_o
);

   localparam logic [7:0] CNT_1_2 = 8'(2 * WIDTH);
   localparam logic [7:0] CNT_2_3 = 8'(3 * WIDTH / 2);
   localparam logic [7:0] CNT_3_4 = 8'(4 * WIDTH / 3);

   always_comb begin
      packed_o = '0;
      count_o  = CNT_1_2;
      case (rate_i)
         RATE_2_3: begin
            // Per input pair: A0 B0 A1 (B1 dropped).
            for (int p = 0; p < WIDTH / 2; p++) begin
               packed_o[3*p]   = mother_a_i[2*p];
               packed_o[3*p+1] = mother_b_i[2*p];
               packed_o[3*p+2] = mother_a_i[2*p+1];
            end
            count_o = CNT_2_3;
         end
         RATE_3_4: begin
            // Per input triple: A0 B0 A1 B2 (B1 and A2 dropped).
            for (int t = 0; t < WIDTH / 3; t++) begin
               packed_o[4*t]   = mother_a_i[3*t];
               packed_o[4*t+1] = mother_b_i[3*t];
               packed_o[4*t+2] = mother_a_i[3*t+1];
               packed_o[4*t+3] = mother_b_i[3*t+2];
            end
            count_o = CNT_3_4;
         end
         default: begin
            for (int i = 0; i < WIDTH; i++) begin
               packed_o[2*i]   = mother_a_i[i];
               packed_o[2*i+1] = mother_b_i[i];
            end
            count_o = CNT_1_2;
         end
      endcase
   end

endmodule

// File: rtl/conv_encoder.sv
// K=7 (133o/171o) convolutional encoder with 802.11 puncturing, WIDTH bits per beat.
// Latency 1 cycle (single output register); s_axis_tready = !m_axis_tvalid || m_axis_tready,
// so a stalled output holds data and shift state while a draining one sustains 1 beat/cycle.
// Ports: aclk, areset (async, active high); s_axis_tdata/tuser(RATE code)/tvalid/tready/tlast;
// m_axis_tdata (coded bits, LSB first)/tuser (valid bit count)/tvalid/tready/tlast.
// Build option CONV_ENCODER_TAIL_EN: clear the shift state after each accepted tlast beat.
module conv_encoder
   import conv_encoder_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [WIDTH-1:0]   s_axis_tdata,
   input  logic [3:0]         s_axis_tuser,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   output logic [2*WIDTH-1:0] m_axis_tdata,
   output logic [7:0]         m_axis_tuser,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast
);

   // state bit 5 = d1 (most recent input) ... bit 0 = d6, so {x, state} is the tap window.
   logic [5:0]         state_q, state_d;
   logic               m_valid_q, m_valid_d;
   logic               m_last_q, m_last_d;
   logic [2*WIDTH-1:0] m_data_q, m_data_d;
   logic [7:0]         m_user_q, m_user_d;

   logic [WIDTH-1:0]   mother_a, mother_b;
   logic [5:0]         state_end;
   logic [2*WIDTH-1:0] punct_data;
   logic [7:0]         punct_cnt;
   rate_e              beat_rate;
   logic               accept;

   assign s_axis_tready = !m_valid_q || m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign beat_rate     = rate_from_code(s_axis_tuser);

   // Whole beat unrolled bit 0 first; each step shifts the window by one.
   always_comb begin : encode
      logic [6:0] win;
      logic [5:0] st;
      st       = state_q;
      win      = '0;
      mother_a = '0;
      mother_b = '0;
      for (int i = 0; i < WIDTH; i++) begin
         win         = {s_axis_tdata[i], st};
         mother_a[i] = ^(win & G0_TAPS);
         mother_b[i] = ^(win & G1_TAPS);
         st          = win[6:1];
      end
      state_end = st;
   end

   conv_puncture #(
      .WIDTH (WIDTH)
   ) u_puncture (
      .mother_a_i (mother_a),
      .mother_b_i (mother_b),
      .rate_i     (beat_rate),
      .packed_o   (punct_data),
      .count_o    (punct_cnt)
   );

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      m_user_d  = m_user_q;
      if (accept) begin
         m_valid_d = 1'b1;
         m_last_d  = s_axis_tlast;
         m_data_d  = punct_data;
         m_user_d  = punct_cnt;
         state_d   = state_end;
`ifdef CONV_ENCODER_TAIL_EN
         if (s_axis_tlast) begin
            state_d = '0;
         end
`endif
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         m_user_q  <= '0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
         m_user_q  <= m_user_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder (WIDTH=24): hand-computed golden beats, handshake
// orders, rate changes, tail option, throughput, random backpressure and mid-stall reset.
module tb_conv_encoder;
   import conv_encoder_pkg::*;

   localparam int W = 24;

   logic           aclk = 1'b0;
   logic           areset;
   logic [W-1:0]   s_tdata;
   logic [3:0]     s_tuser;
   logic           s_tvalid, s_tready, s_tlast;
   logic [2*W-1:0] m_tdata;
   logic [7:0]     m_tuser;
   logic           m_tvalid, m_tready, m_tlast;

   always #5 aclk = ~aclk;

   conv_encoder #(.WIDTH(W)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast)
   );

   typedef struct {
      logic [2*W-1:0] d;
      logic [7:0]     u;
      logic           l;
   } beat_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          out_cnt = 0;
   int          rdy_mode = 0;      // 0: ready high, 1: ready low, 2: random
   int          last_acc_cyc = 0;
   beat_t       exp_q[$];
   logic        stall_prev = 1'b0;
   logic [57:0] held = '0;
   logic [6:1]  md = '0;           // model shift register, md[k] = input k bits earlier

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference: serial encoder straight from the generator equations, puncturing by keep masks.
   function automatic beat_t model_beat(input logic [W-1:0] x, input logic [3:0] code,
                                        input logic last);
      beat_t      r;
      int         per, n, idx;
      logic [5:0] keep;
      logic       a, b;
      case (code)
         RATE_48M:                              begin per = 4; keep = 6'b000111; end
         RATE_9M, RATE_18M, RATE_36M, RATE_54M: begin per = 6; keep = 6'b100111; end
         default:                               begin per = 2; keep = 6'b000011; end
      endcase
      r.d = '0;
      n   = 0;
      for (int i = 0; i < W; i++) begin
         a  = x[i] ^ md[2] ^ md[3] ^ md[5] ^ md[6];
         b  = x[i] ^ md[1] ^ md[2] ^ md[3] ^ md[6];
         md = {md[5:1], x[i]};
         for (int j = 0; j < 2; j++) begin
            idx = (2 * i + j) % per;
            if (keep[idx]) begin
               r.d[n] = (j == 0) ? a : b;
               n++;
            end
         end
      end
      r.u = 8'(n);
      r.l = last;
`ifdef CONV_ENCODER_TAIL_EN
      if (last) md = '0;
`endif
      return r;
   endfunction

   // Output monitor: owns m_tready, checks hold-while-stalled and scoreboard order.
   initial begin
      beat_t e;
      m_tready = 1'b0;
      forever begin
         @(negedge aclk);
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (!areset && stall_prev)
            check("stall_hold", 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'(held));
         stall_prev = !areset && m_tvalid && !m_tready;
         held       = {m_tvalid, m_tlast, m_tuser, m_tdata};
         if (!areset && m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("extra_beat", 64'(out_cnt), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(m_tdata), 64'(e.d));
               check("out_user", 64'(m_tuser), 64'(e.u));
               check("out_last", 64'(m_tlast), 64'(e.l));
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [3:0] r, input logic l,
                       input logic push);
      beat_t b;
      int    n = 0;
      b = model_beat(d, r, l);
      if (push) exp_q.push_back(b);
      @(negedge aclk);
      s_tdata = d; s_tuser = r; s_tlast = l; s_tvalid = 1'b1;
      #2;
      while (!s_tready && n < 200) begin
         @(negedge aclk);
         #2;
         n++;
      end
      check("send_ready", 64'(s_tready), 64'(1));
      @(posedge aclk);
      #1;
      last_acc_cyc = cyc;
   endtask

   task automatic idle();
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge aclk);
         n++;
      end
      repeat (3) @(negedge aclk);
      #3;
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
      exp_q.delete();
      md = '0;
      repeat (2) @(negedge aclk);
      #2;
      check("rst_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_tdata",  64'(m_tdata),  64'(0));
      check("rst_tuser",  64'(m_tuser),  64'(0));
      check("rst_tlast",  64'(m_tlast),  64'(0));
      areset = 1'b0;
      #1;
      check("rst_tready", 64'(s_tready), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]     codes [9];
      logic [2*W-1:0] tail2;
      int             n0, a0;
      codes = '{RATE_6M, RATE_9M, RATE_12M, RATE_18M, RATE_24M,
                RATE_36M, RATE_48M, RATE_54M, 4'b0000};
      areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;

      // SIGNAL-field beat at 6M under three handshake orders.
      for (int k = 0; k < 3; k++) begin
         do_reset();
         n0 = out_cnt;
         rdy_mode = (k == 0) ? 1 : 0;
         if (k == 1) repeat (3) @(negedge aclk);
         exp_q.push_back('{48'h000e7c40858b, 8'd48, 1'b0});
         send(24'h000c8d, RATE_6M, 1'b0, 1'b0);
         idle();
         if (k == 0) begin
            repeat (4) @(negedge aclk);
            #2;
            check("hold_valid", 64'(m_tvalid), 64'(1));
            rdy_mode = 0;
         end
         drain();
         check("one_beat", 64'(out_cnt - n0), 64'(1));
      end

      // 2/3: all ones from reset.
      do_reset();
      exp_q.push_back('{48'h000ffffffe77, 8'd36, 1'b1});
      send('1, RATE_48M, 1'b1, 1'b0);
      idle();
      drain();

      // 3/4: all ones from reset.
      do_reset();
      exp_q.push_back('{48'h0000ffffff5f, 8'd32, 1'b0});
      send('1, RATE_9M, 1'b0, 1'b0);
      idle();
      drain();

      // Back-to-back rate changes, including an unknown code (falls to 1/2).
      do_reset();
      exp_q.push_back('{48'hfffffffff167, 8'd48, 1'b0});
      exp_q.push_back('{48'h0000ffffffff, 8'd32, 1'b0});
      exp_q.push_back('{48'hffffffffffff, 8'd48, 1'b1});
      send('1, RATE_6M, 1'b0, 1'b0);
      send('1, RATE_54M, 1'b0, 1'b0);
      send('1, 4'b0000, 1'b1, 1'b0);
      idle();
      drain();

      // Two identical one-beat frames.
`ifdef CONV_ENCODER_TAIL_EN
      tail2 = 48'hfffffffff167;
`else
      tail2 = 48'hffffffffffff;
`endif
      do_reset();
      exp_q.push_back('{48'hfffffffff167, 8'd48, 1'b1});
      exp_q.push_back('{tail2, 8'd48, 1'b1});
      send('1, RATE_6M, 1'b1, 1'b0);
      send('1, RATE_6M, 1'b1, 1'b0);
      idle();
      drain();

      // 10 consecutive 9M beats with ready high: one accept per cycle.
      do_reset();
      rdy_mode = 0;
      send(W'($urandom), RATE_9M, 1'b0, 1'b1);
      a0 = last_acc_cyc;
      for (int i = 1; i < 10; i++) send(W'($urandom), RATE_9M, 1'b0, 1'b1);
      check("thru_cycles", 64'(last_acc_cyc - a0), 64'(9));
      idle();
      drain();

      // Random backpressure over 20 beats with mixed rates and tlast.
      do_reset();
      n0 = out_cnt;
      rdy_mode = 2;
      for (int i = 0; i < 20; i++)
         send(W'($urandom), codes[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), 1'b1);
      idle();
      drain();
      check("rand_count", 64'(out_cnt - n0), 64'(20));

      // Reset while the output is stalled: beat discarded, nothing after release.
      do_reset();
      rdy_mode = 1;
      send(24'h000c8d, RATE_6M, 1'b0, 1'b0);
      idle();
      repeat (3) @(negedge aclk);
      #2;
      check("stall_valid", 64'(m_tvalid), 64'(1));
      @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check("midrst_valid", 64'(m_tvalid), 64'(0));
      check("midrst_data",  64'(m_tdata),  64'(0));
      @(negedge aclk);
      areset = 1'b0;
      rdy_mode = 0;
      n0 = out_cnt;
      repeat (5) @(negedge aclk);
      #3;
      check("no_partial", 64'(out_cnt - n0), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 24, input bits per beat; multiple of 6, range 6..96.
REQ-002 SHALL have port aclk  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_axis_tdata  in  WIDTH  input bits, bit 0 encoded first.
REQ-005 SHALL have port s_axis_tuser  in  4  IEEE 802.11 RATE code from ieee80211_defs.v, sampled per beat.
REQ-006 SHALL have ports s_axis_tvalid  in  1 / s_axis_tready  out  1 / s_axis_tlast  in  1, AXI-Stream slave handshake.
REQ-007 SHALL have port m_axis_tdata  out  2*WIDTH  coded bits, LSB first; unused upper bits zero.
REQ-008 SHALL have port m_axis_tuser  out  8  count of valid coded bits in m_axis_tdata.
REQ-009 SHALL have ports m_axis_tvalid  out  1 / m_axis_tready  in  1 / m_axis_tlast  out  1, AXI-Stream master handshake.

Function
REQ-010 SHALL implement the K=7 code g0=133o, g1=171o: A = x^d2^d3^d5^d6, B = x^d1^d2^d3^d6, dk = input k bits earlier.
REQ-011 SHALL carry the 6-bit shift state across beats; a beat is encoded serially bit 0..WIDTH-1, but combinationally within one cycle.
REQ-012 SHALL map rate: 6M/12M/24M -> 1/2; 48M -> 2/3; 9M/18M/36M/54M -> 3/4; any other code -> 1/2.
REQ-013 Rate 1/2 SHALL emit A0 B0 A1 B1 ... (bit 2i = Ai, 2i+1 = Bi); count = 2*WIDTH.
REQ-014 Rate 2/3 SHALL emit per input pair A0 B0 A1 (B1 dropped); count = 3*WIDTH/2.
REQ-015 Rate 3/4 SHALL emit per input triple A0 B0 A1 B2 (B1, A2 dropped); count = 4*WIDTH/3.
REQ-016 Puncturing pattern SHALL restart at bit 0 of every beat (WIDTH multiple of 6 keeps period aligned).
REQ-017 Output SHALL be a single register stage: latency 1 cycle from accepted input beat to m_axis_tvalid.
REQ-018 s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready; accept and drain in same cycle allowed, sustaining 1 beat/cycle.
REQ-019 While m_axis_tvalid && !m_axis_tready, m_axis_tdata/tuser/tlast SHALL hold stable and shift state SHALL not advance.
REQ-020 m_axis_tlast SHALL be s_axis_tlast of the corresponding input beat.
REQ-021 Rate changes between beats SHALL take effect on the next accepted beat, no bubble.

Reset
REQ-022 On areset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, shift state=0; s_axis_tready=1 after release.
REQ-023 Reset mid-frame SHALL discard the held output beat and all shift state; no partial output after release.

Configuration
REQ-024 Macro CONV_ENCODER_TAIL_EN defined: shift state SHALL clear to zero after the beat with s_axis_tlast=1 is accepted, so each frame starts from zero state.
REQ-025 Macro CONV_ENCODER_TAIL_EN undefined: tlast SHALL only propagate; state persists across frames, cleared only by reset.

Structure
REQ-026 Generator taps, rate enum (RATE_1_2, RATE_2_3, RATE_3_4) and RATE-code-to-rate function SHALL live in shared package/include alongside ieee80211_defs.v.
REQ-027 Puncturing SHALL be one sub-module, conv_puncture (mother-code bits + rate in, packed bits + count out, pure combinational).

Verification
REQ-028 WIDTH=24, RATE_6M, tdata 24'h000c8d from reset -> m_axis_tdata 48'h000e7c40858b, tuser 48.
REQ-029 Same beat, three handshake orders (tvalid before tready, tready before tvalid, both together) -> identical output, one beat each.
REQ-030 RATE_9M, 10 consecutive beats from data_after_scrambling vectors, m_axis_tready=1 -> match data_after_encoding, tuser 32 each, 1 beat/cycle.
REQ-031 RATE_48M, tdata all ones from reset -> tuser 36, upper 12 bits zero, bits match 2/3 golden model.
REQ-032 m_axis_tready toggled randomly over 20 beats -> no loss/duplication, output stable while stalled; areset asserted mid-stall -> tvalid=0 next edge.
REQ-033 With CONV_ENCODER_TAIL_EN, frame (tlast) then identical frame -> identical outputs; without it -> second frame differs when first ends with nonzero state.
